// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared types and encodings for the multicycle MIPS control
//               FSM. Holds the state enum, the opcode and funct constants, the
//               datapath select encodings and the fault codes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_ADDIEX = 4'd8,
        ST_ADDIWB = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_HALT   = 4'd12
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Funct codes that take the shift-amount operand
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    // ALU B operand select
    localparam logic [2:0] SRCB_REG   = 3'd0;
    localparam logic [2:0] SRCB_FOUR  = 3'd1;
    localparam logic [2:0] SRCB_IMM   = 3'd2;
    localparam logic [2:0] SRCB_IMMSH = 3'd3;
    localparam logic [2:0] SRCB_SHAMT = 3'd4;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Stall counter for the memory handshake. Clears on request,
//               counts stalled cycles, and flags the stalled cycle whose
//               increment would bring the count up to TIMEOUT.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clr         - clear count (entry to a memory state)
//               i_en          - stalled cycle (request high, not ready)
//               o_expired     - this stalled cycle is the limit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TO_W-1:0] C_LIMIT_M1 = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_count_q;
    logic [TO_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_en) begin
            w_count_d = r_count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    // The stall counted in this cycle is the TIMEOUT-th one. Completion in
    // the same cycle is excluded by the caller because i_en needs !ready.
    assign o_expired = i_en && (r_count_q == C_LIMIT_M1);

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mips_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl_hs
// Description : Multicycle MIPS control FSM with a req/ready memory
//               handshake, memory timeout, illegal-opcode halt and a
//               retired-instruction counter.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               OP_code, Funct      - decoded instruction fields
//               mem_ready           - memory completes the access this cycle
//               mem_req, MemWrite, IorD, IRWrite, MemtoReg, RegDst, RegWrite,
//               ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond
//                                   - datapath controls
//               halted, fault       - halt status and cause
//               retired             - completed instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl_hs
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8,
    parameter int CNT_W    = 32,
    parameter int SHIFT_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP_code,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [2:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state_q;
    state_t           w_state_d;
    logic [1:0]       r_fault_q;
    logic [1:0]       w_fault_d;
    logic [CNT_W-1:0] r_retired_q;
    logic [CNT_W-1:0] w_retired_d;
    logic             w_retire;
    logic             w_expired;
    logic             w_shift;

    assign w_shift = (SHIFT_EN != 0) && ((Funct == FN_SLL) || (Funct == FN_SRL));

    // Entry to any state (memory states included) restarts the stall count.
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_state_d != r_state_q),
        .i_en      (mem_req && !mem_ready),
        .o_expired (w_expired)
    );

    // Next-state, fault and retire logic
    always_comb begin
        w_state_d = r_state_q;
        w_fault_d = r_fault_q;
        w_retire  = 1'b0;
        case (r_state_q)
            ST_FETCH, ST_MEMRD, ST_MEMWR: begin
                if (mem_ready) begin
                    if (r_state_q == ST_FETCH) begin
                        w_state_d = ST_DECODE;
                    end else if (r_state_q == ST_MEMRD) begin
                        w_state_d = ST_MEMWB;
                    end else begin
                        w_state_d = ST_FETCH;
                        w_retire  = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_d = ST_HALT;
                    w_fault_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (OP_code)
                    OP_LW, OP_SW: w_state_d = ST_MEMADR;
                    OP_RTYPE:     w_state_d = ST_EXEC;
                    OP_ADDI:      w_state_d = ST_ADDIEX;
                    OP_BEQ:       w_state_d = ST_BRANCH;
                    OP_J:         w_state_d = ST_JUMP;
                    default: begin
                        w_state_d = ST_HALT;
                        w_fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR: w_state_d = (OP_code == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_EXEC:   w_state_d = ST_RWB;
            ST_ADDIEX: w_state_d = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: begin
                w_state_d = ST_FETCH;
                w_retire  = 1'b1;
            end
            ST_HALT:   w_state_d = ST_HALT;
            default:   w_state_d = ST_FETCH;
        endcase
        w_retired_d = r_retired_q + (w_retire ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_FETCH;
            r_fault_q   <= FAULT_NONE;
            r_retired_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_fault_q   <= w_fault_d;
            r_retired_q <= w_retired_d;
        end
    end

    // Moore decode; only the fetch write strobes look at mem_ready. Everything
    // is forced quiet while rst is held so an in-flight access is abandoned.
    always_comb begin
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        case (r_state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE: ALUSrcB = SRCB_IMMSH;
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = w_shift ? SRCB_SHAMT : SRCB_REG;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_ADDIWB: RegWrite = 1'b1;
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
        halted = (r_state_q == ST_HALT);
        fault  = r_fault_q;
        if (rst) begin
            mem_req     = 1'b0;
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_REG;
            ALUOp       = ALUOP_ADD;
            PCSource    = PCSRC_ALU;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            halted      = 1'b0;
            fault       = FAULT_NONE;
        end
    end

    assign retired = r_retired_q;

endmodule : mips_mc_ctrl_hs
`default_nettype wire

// File: tb/tb_mips_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mc_ctrl_hs
// Description : Self-checking bench for mips_mc_ctrl_hs. Two instances share
//               stimulus: A (SHIFT_EN=1, 32-bit count) and B (SHIFT_EN=0,
//               3-bit count so the retired counter wraps). Both use TIMEOUT=4.
//               Each task queues per-cycle expectations, then replays them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl_hs;

    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                   S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_ADDIEX = 9,
                   S_ADDIWB = 10, S_BRANCH = 11, S_JUMP = 12, S_HALT = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  OP_code;
    logic [5:0]  Funct;
    logic        mem_ready;

    logic        mreq_a, mw_a, iord_a, irw_a, m2r_a, rdst_a, rw_a, sa_a, pcw_a, pcwc_a, hlt_a;
    logic [2:0]  srcb_a;
    logic [1:0]  aop_a, pcs_a, flt_a;
    logic [31:0] retired_a;
    logic        mreq_b, mw_b, iord_b, irw_b, m2r_b, rdst_b, rw_b, sa_b, pcw_b, pcwc_b, hlt_b;
    logic [2:0]  srcb_b;
    logic [1:0]  aop_b, pcs_b, flt_b;
    logic [2:0]  retired_b;

    logic [19:0] ctl_a, ctl_b;
    assign ctl_a = {mreq_a, mw_a, iord_a, irw_a, m2r_a, rdst_a, rw_a, sa_a, srcb_a,
                    aop_a, pcs_a, pcw_a, pcwc_a, hlt_a, flt_a};
    assign ctl_b = {mreq_b, mw_b, iord_b, irw_b, m2r_b, rdst_b, rw_b, sa_b, srcb_b,
                    aop_b, pcs_b, pcw_b, pcwc_b, hlt_b, flt_b};

    always #5 clk = ~clk;

    mips_mc_ctrl_hs #(.TIMEOUT(4), .TO_W(8), .CNT_W(32), .SHIFT_EN(1)) dut_a (
        .clk(clk), .rst(rst), .OP_code(OP_code), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mreq_a), .MemWrite(mw_a), .IorD(iord_a), .IRWrite(irw_a),
        .MemtoReg(m2r_a), .RegDst(rdst_a), .RegWrite(rw_a), .ALUSrcA(sa_a),
        .ALUSrcB(srcb_a), .ALUOp(aop_a), .PCSource(pcs_a), .PCWrite(pcw_a),
        .PCWriteCond(pcwc_a), .halted(hlt_a), .fault(flt_a), .retired(retired_a)
    );

    mips_mc_ctrl_hs #(.TIMEOUT(4), .TO_W(3), .CNT_W(3), .SHIFT_EN(0)) dut_b (
        .clk(clk), .rst(rst), .OP_code(OP_code), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mreq_b), .MemWrite(mw_b), .IorD(iord_b), .IRWrite(irw_b),
        .MemtoReg(m2r_b), .RegDst(rdst_b), .RegWrite(rw_b), .ALUSrcA(sa_b),
        .ALUSrcB(srcb_b), .ALUOp(aop_b), .PCSource(pcs_b), .PCWrite(pcw_b),
        .PCWriteCond(pcwc_b), .halted(hlt_b), .fault(flt_b), .retired(retired_b)
    );

    typedef struct {
        logic        r;
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] ca;
        logic [19:0] cb;
        logic        ret;
    } rec_t;

    rec_t       sb[$];
    logic [5:0] g_op = 6'h00;
    logic [5:0] g_fn = 6'h20;
    int         nchk = 0;
    int         npass = 0;
    int         exp_ret = 0;
    int         cyc = 0;

    // Expected control vector for one cycle, straight from the state table.
    function automatic logic [19:0] mdl(input int st, input logic rdy,
                                        input logic [2:0] exsrcb, input logic [1:0] flt);
        logic       mreq, mw, iord, irw, m2r, rdst, rw, sa, pcw, pcwc, hlt;
        logic [2:0] srcb;
        logic [1:0] aop, pcs;
        {mreq, mw, iord, irw, m2r, rdst, rw, sa, pcw, pcwc, hlt} = '0;
        srcb = 3'd0; aop = 2'd0; pcs = 2'd0;
        case (st)
            S_FETCH:  begin mreq = 1; srcb = 3'd1; irw = rdy; pcw = rdy; end
            S_DECODE: srcb = 3'd3;
            S_MEMADR: begin sa = 1; srcb = 3'd2; end
            S_MEMRD:  begin mreq = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mreq = 1; mw = 1; iord = 1; end
            S_EXEC:   begin sa = 1; srcb = exsrcb; aop = 2'b10; end
            S_RWB:    begin rw = 1; rdst = 1; end
            S_ADDIEX: begin sa = 1; srcb = 3'd2; end
            S_ADDIWB: rw = 1;
            S_BRANCH: begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'd1; end
            S_JUMP:   begin pcw = 1; pcs = 2'd2; end
            S_HALT:   hlt = 1;
            default:  ;
        endcase
        return {mreq, mw, iord, irw, m2r, rdst, rw, sa, srcb, aop, pcs, pcw, pcwc, hlt, flt};
    endfunction

    task automatic enq(input logic r, input logic rdy, input int st,
                       input logic [1:0] flt, input logic ret);
        rec_t       e;
        logic [2:0] xa;
        xa    = (g_fn == 6'h00 || g_fn == 6'h02) ? 3'd4 : 3'd0;
        e.r   = r;
        e.rdy = rdy;
        e.op  = g_op;
        e.fn  = g_fn;
        e.ca  = mdl(st, rdy, xa, flt);
        e.cb  = mdl(st, rdy, 3'd0, flt);
        e.ret = ret;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rec_t e;
        rst = 1'b1; mem_ready = 1'b0; OP_code = 6'h00; Funct = 6'h20;
        @(posedge clk); #1;
        enq(1, 0, S_RST, 2'd0, 0);
        enq(1, 1, S_RST, 2'd0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL reset_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL reset_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_lw_ready();
        rec_t e;
        g_op = 6'h23;
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 1, S_DECODE, 2'd0, 0);
        enq(0, 1, S_MEMADR, 2'd0, 0);
        enq(0, 1, S_MEMRD, 2'd0, 0);
        enq(0, 1, S_MEMWB, 2'd0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL lw_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL lw_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_fetch_stall();
        rec_t e;
        g_op = 6'h08;
        for (int i = 0; i < 3; i++) enq(0, 0, S_FETCH, 2'd0, 0);
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 0, S_DECODE, 2'd0, 0);
        enq(0, 0, S_ADDIEX, 2'd0, 0);
        enq(0, 0, S_ADDIWB, 2'd0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL stall_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL stall_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_sw();
        rec_t e;
        g_op = 6'h2B;
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 0, S_DECODE, 2'd0, 0);
        enq(0, 0, S_MEMADR, 2'd0, 0);
        enq(0, 0, S_MEMWR, 2'd0, 0);
        enq(0, 1, S_MEMWR, 2'd0, 1);
        enq(0, 0, S_FETCH, 2'd0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL sw_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL sw_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_rtype_shift();
        rec_t e;
        g_op = 6'h00;
        // sw test left the FSM in FETCH; complete that fetch as an sll
        g_fn = 6'h00;
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 0, S_DECODE, 2'd0, 0);
        enq(0, 0, S_EXEC, 2'd0, 0);
        enq(0, 0, S_RWB, 2'd0, 1);
        g_fn = 6'h20;
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 0, S_DECODE, 2'd0, 0);
        enq(0, 0, S_EXEC, 2'd0, 0);
        enq(0, 0, S_RWB, 2'd0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL rtype_ctl cyc=%0d fn=%h got=%h/%h exp=%h/%h", cyc, e.fn, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL rtype_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t e;
        for (int k = 0; k < 2; k++) begin
            g_op = 6'h04;
            enq(0, 1, S_FETCH, 2'd0, 0);
            enq(0, 0, S_DECODE, 2'd0, 0);
            enq(0, 1, S_BRANCH, 2'd0, 1);
            g_op = 6'h02;
            enq(0, 1, S_FETCH, 2'd0, 0);
            enq(0, 0, S_DECODE, 2'd0, 0);
            enq(0, 0, S_JUMP, 2'd0, 1);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL b2b_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL b2b_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_illegal_halt();
        rec_t e;
        g_op = 6'h3F;
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 0, S_DECODE, 2'd0, 0);
        for (int i = 0; i < 10; i++) enq(0, i[0], S_HALT, 2'b01, 0);
        enq(1, 0, S_RST, 2'd0, 0);
        g_op = 6'h23;
        enq(0, 0, S_FETCH, 2'd0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL illegal_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL illegal_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    task automatic test_timeout();
        rec_t e;
        g_op = 6'h23;
        enq(1, 0, S_RST, 2'd0, 0);
        for (int i = 0; i < 4; i++) enq(0, 0, S_FETCH, 2'd0, 0);
        enq(0, 1, S_HALT, 2'b10, 0);
        enq(0, 0, S_HALT, 2'b10, 0);
        enq(1, 0, S_RST, 2'd0, 0);
        // Ready lands exactly in the limit cycle, for fetch and for the load.
        for (int i = 0; i < 3; i++) enq(0, 0, S_FETCH, 2'd0, 0);
        enq(0, 1, S_FETCH, 2'd0, 0);
        enq(0, 0, S_DECODE, 2'd0, 0);
        enq(0, 0, S_MEMADR, 2'd0, 0);
        for (int i = 0; i < 3; i++) enq(0, 0, S_MEMRD, 2'd0, 0);
        enq(0, 1, S_MEMRD, 2'd0, 0);
        enq(0, 0, S_MEMWB, 2'd0, 1);
        enq(0, 0, S_FETCH, 2'd0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r; mem_ready = e.rdy; OP_code = e.op; Funct = e.fn;
            @(negedge clk);
            nchk++;
            if (ctl_a !== e.ca || ctl_b !== e.cb) $display("FAIL timeout_ctl cyc=%0d got=%h/%h exp=%h/%h", cyc, ctl_a, ctl_b, e.ca, e.cb);
            else npass++;
            @(posedge clk); #1;
            if (e.r) exp_ret = 0; else if (e.ret) exp_ret++;
            nchk++;
            if (retired_a !== 32'(exp_ret) || retired_b !== 3'(exp_ret)) $display("FAIL timeout_retired cyc=%0d got=%0d/%0d exp=%0d", cyc, retired_a, retired_b, exp_ret);
            else npass++;
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_lw_ready();
        test_fetch_stall();
        test_sw();
        test_rtype_shift();
        test_back_to_back();
        test_illegal_halt();
        test_timeout();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_mips_mc_ctrl_hs
`default_nettype wire

// File: doc/mips_mc_ctrl_hs.md
Name: mips_mc_ctrl_hs

Overview:
Parametrised multicycle control FSM for the next-generation MIPS core. It drives the same datapath control set as the current core: PC/IR/register-file enables, ALU source and op selects, and PC source. It adds a req/ready memory handshake with variable-latency stall, a memory timeout, illegal-opcode halt, and a retired-instruction counter. It sits between the instruction decoder outputs and the datapath muxes/registers.

Parameters:
TIMEOUT, 255, max cycles mem_req may wait for mem_ready before fault (1..2^TO_W-1)
TO_W, 8, width of timeout counter
CNT_W, 32, width of retired-instruction counter
SHIFT_EN, 1, 1 = R-type sll/srl use shamt path (ALUSrcB=4); 0 = treated as plain R-type

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
OP_code  in  6  decoded opcode
Funct  in  6  decoded funct
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request; held until mem_ready
MemWrite  out  1  store strobe, valid with mem_req
IorD  out  1  0 = PC address, 1 = ALUOut address
IRWrite  out  1  latch instruction
MemtoReg  out  1  1 = MDR to register file
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register-file write enable
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  3  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2, 4 = shamt
ALUOp  out  2  00 add, 01 sub, 10 funct-driven
PCSource  out  2  0 = ALU, 1 = ALUOut, 2 = jump
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
halted  out  1  FSM in HALT
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout
retired  out  CNT_W  instructions completed

Behaviour:
- Reset: the clock and reset ports are clk and rst; one clock; reset is synchronous and active-high. On rst: state=FETCH, all strobes 0, ALUSrcB/ALUOp/PCSource=0, fault=0, retired=0, timeout counter=0. rst mid-access drops mem_req on the next edge; no write retires.
- Outputs are Moore-decoded from state, except IRWrite, PCWrite in FETCH, and MemWrite/mem_req completion, which are qualified by mem_ready.
- States and transitions:
  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0. IRWrite and PCWrite pulse only in the mem_ready cycle. Then go to DECODE; otherwise stay.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=00 (branch target precompute). Dispatch: 0x23/0x2B -> MEMADR; 0x00 -> EXEC; 0x08 -> ADDIEX; 0x04 -> BRANCH; 0x02 -> JUMP; else -> HALT with fault=01.
  - MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, IorD=1. On mem_ready -> MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retire, -> FETCH.
  - MEMWR: mem_req=1, MemWrite=1, IorD=1. On mem_ready: retire, -> FETCH.
  - EXEC: ALUSrcA=1, ALUOp=10. ALUSrcB=4 if SHIFT_EN and Funct in {0x00, 0x02}; else 0. -> RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0. Retire, -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=00. -> ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0. Retire, -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=1. Retire, -> FETCH.
  - JUMP: PCWrite=1, PCSource=2. Retire, -> FETCH.
  - HALT: all strobes 0, halted=1. Sticky until rst.
- Timeout:
  - Counter clears on entry to any mem state and increments each cycle with mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT while still not ready, go to HALT with fault=10. mem_ready in the same cycle as the limit wins: access completes, no fault.
- retired increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum
  - opcode constants: OP_RTYPE=0x00, OP_LW=0x23, OP_SW=0x2B, OP_BEQ=0x04, OP_J=0x02, OP_ADDI=0x08
  - funct constants: FN_SLL=0x00, FN_SRL=0x02
  - ALUSrcB, ALUOp and PCSource encodings
  - fault codes
- One sub-module: mem_timeout_ctr (clear, count enable, TIMEOUT compare, expired flag).

Test Plan:
1. Reset, then mem_ready tied 1, lw fetched: FETCH, DECODE, MEMADR, MEMRD, MEMWB. Exactly 5 cycles; one IRWrite pulse and one PCWrite pulse; retired=1.
2. Fetch with mem_ready delayed 3 cycles: mem_req high 4 cycles; IRWrite/PCWrite asserted only in cycle 4; no duplicate PC increment.
3. sw with mem_ready at cycle 2: MemWrite=1 and IorD=1 for both cycles; returns to FETCH; retired increments once.
4. R-type Funct=0x00 with SHIFT_EN=1: ALUSrcB=4 in EXEC. With SHIFT_EN=0: ALUSrcB=0. Funct=0x20 gives ALUSrcB=0 in both cases.
5. OP_code=0x3F: HALT with fault=01, halted=1, all strobes 0 for 10 cycles. rst clears everything; next state is FETCH.
6. TIMEOUT=4, mem_ready never asserted: HALT with fault=10 after exactly 4 stall cycles. Rerun with mem_ready arriving in the limit cycle: completes normally, fault=00.
